// File: rtl/rx_symb_buf_pkg.sv
// -----------------------------------------------------------------------------
// rx_symb_buf_pkg
// Shared decoder package for the received-symbol buffer: default symbol width,
// codeword length and start latency, the replay FSM state encoding, and a
// helper used for the elaboration-time size check.
// -----------------------------------------------------------------------------
package rx_symb_buf_pkg;

   localparam int SYM_BW_DEF    = 8;
   localparam int N_NUM_DEF     = 255;
   localparam int START_LAT_DEF = 3;

   // Replay FSM: IDLE waits for rd_start, WAIT covers the start latency,
   // READ streams the stored codeword out.
   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_WAIT = 2'd1,
      RD_READ = 2'd2
   } rd_state_t;

   // True when a codeword of n_num symbols can be indexed 1..n_num by a
   // sym_bw-bit counter without wrapping.
   function automatic bit n_num_fits(input int sym_bw, input int n_num);
      return (n_num >= 1) && (n_num <= (1 << sym_bw) - 1);
   endfunction

endpackage

// File: rtl/rx_symb_buf_if.sv
// -----------------------------------------------------------------------------
// rx_symb_buf_if
// Bundles the symbol-input handshake and the replay-side signals of
// rx_symb_buf.
//   in_val / in_sym / in_rdy : symbol input. A symbol transfers on a rising
//       clock edge where in_val=1 and in_rdy=1, and on no other edge. in_rdy
//       does not depend on in_val; the source holds in_val and in_sym stable
//       until the transfer happens.
//   rd_start      : one-cycle replay request from the Forney stage
//   symb_cnt      : replay index 1..N_NUM, 0 when nothing is replayed
//   symb_with_err : replayed stored symbol, aligned with symb_cnt
//   blk_avail     : a complete codeword is stored and not being replayed
//   rd_err        : one-cycle pulse, rd_start was rejected
// Modports: master = symbol source / corrector side, slave = the buffer.
// -----------------------------------------------------------------------------
interface rx_symb_buf_if
   import rx_symb_buf_pkg::*;
#(
   parameter int SYM_BW = SYM_BW_DEF
);

   logic              in_val;
   logic [SYM_BW-1:0] in_sym;
   logic              in_rdy;
   logic              rd_start;
   logic [SYM_BW-1:0] symb_cnt;
   logic [SYM_BW-1:0] symb_with_err;
   logic              blk_avail;
   logic              rd_err;

   modport master (
      output in_val, in_sym, rd_start,
      input  in_rdy, symb_cnt, symb_with_err, blk_avail, rd_err
   );

   modport slave (
      input  in_val, in_sym, rd_start,
      output in_rdy, symb_cnt, symb_with_err, blk_avail, rd_err
   );

endinterface

// File: rtl/rx_symb_buf_dpram.sv
// -----------------------------------------------------------------------------
// rs_sym_dpram
// Simple dual-port RAM holding two banks of N_NUM symbols. One write port,
// one read port with a single registered read stage. Addresses are
// {bank, index}; index must stay below N_NUM. Contents are not reset.
// Ports:
//   clk              : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : read request, data appears on rd_data after the edge
//   rd_data          : registered read data
// -----------------------------------------------------------------------------
module rs_sym_dpram
   import rx_symb_buf_pkg::*;
#(
   parameter int SYM_BW = SYM_BW_DEF,
   parameter int N_NUM  = N_NUM_DEF
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [SYM_BW:0]   wr_addr,
   input  logic [SYM_BW-1:0] wr_data,
   input  logic              rd_en,
   input  logic [SYM_BW:0]   rd_addr,
   output logic [SYM_BW-1:0] rd_data
);

   logic [SYM_BW-1:0] mem [0:1][0:N_NUM-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr[SYM_BW]][wr_addr[SYM_BW-1:0]] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr[SYM_BW]][rd_addr[SYM_BW-1:0]];
      end
   end

endmodule

// File: rtl/rx_symb_buf.sv
// -----------------------------------------------------------------------------
// rx_symb_buf
// Ping-pong buffer for received Reed-Solomon symbols. Incoming symbols fill
// one bank while the other bank, once complete, is replayed to the corrector
// in step with its symb_cnt. The replay starts START_LAT cycles after an
// accepted rd_start and runs N_NUM consecutive cycles.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : rx_symb_buf_if.slave (symbol input handshake + replay side)
//   dbg_state  : current replay FSM state
// -----------------------------------------------------------------------------
module rx_symb_buf
   import rx_symb_buf_pkg::*;
#(
   parameter int SYM_BW    = SYM_BW_DEF,
   parameter int N_NUM     = N_NUM_DEF,
   parameter int START_LAT = START_LAT_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   rx_symb_buf_if.slave bus,
   output rd_state_t    dbg_state
);

   // Elaboration-time parameter checks.
   if (!n_num_fits(SYM_BW, N_NUM)) begin : g_bad_n_num
      $error("rx_symb_buf: N_NUM must be within 1..2^SYM_BW-1");
   end
   if (START_LAT < 2) begin : g_bad_lat
      $error("rx_symb_buf: START_LAT must be at least 2");
   end

   localparam int LW = $clog2(START_LAT + 1);
   localparam logic [SYM_BW-1:0] LAST_IDX  = SYM_BW'(N_NUM - 1);
   localparam logic [SYM_BW-1:0] N_CNT     = SYM_BW'(N_NUM);
   localparam logic [LW-1:0]     WAIT_LAST = LW'(START_LAT - 2);

   // ---------------------------------------------------------------- state
   rd_state_t         state_q, state_nxt;
   logic [1:0]        full_q, full_nxt;
   logic              wb_q, wb_nxt;
   logic              rb_q, rb_nxt;
   logic [SYM_BW-1:0] wcnt_q;
   logic              in_rdy_q;
   logic [LW-1:0]     wait_q, wait_nxt;
   logic [SYM_BW-1:0] ridx_q, ridx_nxt;
   logic              q_vld_q;
   logic [SYM_BW-1:0] q_cnt_q;
   logic [SYM_BW-1:0] symb_cnt_q;
   logic [SYM_BW-1:0] symb_err_q;
   logic              rd_err_q;
   logic              blk_avail_q;

   // ---------------------------------------------------------- comb signals
   logic              wr_fire;
   logic              wr_last;
   logic              ram_rd_en;
   logic [SYM_BW-1:0] ram_rd_idx;
   logic [SYM_BW-1:0] ram_rd_data;
   logic              rd_rel;
   logic              rd_reject;

   // ------------------------------------------------------------ write side
   assign wr_fire = bus.in_val && in_rdy_q;
   assign wr_last = wr_fire && (wcnt_q == LAST_IDX);

   rs_sym_dpram #(
      .SYM_BW (SYM_BW),
      .N_NUM  (N_NUM)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr ({wb_q, wcnt_q}),
      .wr_data (bus.in_sym),
      .rd_en   (ram_rd_en),
      .rd_addr ({rb_q, ram_rd_idx}),
      .rd_data (ram_rd_data)
   );

   // ------------------------------------------------------- replay FSM comb
   // Address i is issued one cycle before its data leaves the RAM register
   // and two cycles before it shows on symb_with_err, so the last WAIT cycle
   // issues index 0 to land symb_cnt=1 exactly START_LAT cycles after the
   // accepted rd_start.
   always_comb begin
      state_nxt  = state_q;
      wait_nxt   = wait_q;
      ridx_nxt   = ridx_q;
      ram_rd_en  = 1'b0;
      ram_rd_idx = ridx_q;
      rd_rel     = 1'b0;
      rd_reject  = 1'b0;
      unique case (state_q)
         RD_IDLE: begin
            if (bus.rd_start) begin
               // full is sampled pre-edge, so a codeword completing on this
               // same edge is not yet eligible.
               if (full_q[rb_q]) begin
                  state_nxt = RD_WAIT;
                  wait_nxt  = '0;
               end else begin
                  rd_reject = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            rd_reject = bus.rd_start;
            if (wait_q == WAIT_LAST) begin
               ram_rd_en  = 1'b1;
               ram_rd_idx = '0;
               ridx_nxt   = SYM_BW'(1);
               state_nxt  = RD_READ;
            end else begin
               wait_nxt = wait_q + 1'b1;
            end
         end
         RD_READ: begin
            rd_reject = bus.rd_start;
            if (ridx_q != N_CNT) begin
               ram_rd_en  = 1'b1;
               ram_rd_idx = ridx_q;
               ridx_nxt   = ridx_q + 1'b1;
            end
            // Last symbol is on the outputs: free the bank on this edge.
            if (symb_cnt_q == N_CNT) begin
               rd_rel    = 1'b1;
               state_nxt = RD_IDLE;
            end
         end
         default: state_nxt = RD_IDLE;
      endcase
   end

   // ----------------------------------------------------- bank bookkeeping
   // A write can only complete a bank that is not full, and a release only
   // frees the full bank being replayed, so the two never hit the same bit.
   always_comb begin
      full_nxt = full_q;
      if (rd_rel) begin
         full_nxt[rb_q] = 1'b0;
      end
      if (wr_last) begin
         full_nxt[wb_q] = 1'b1;
      end
      wb_nxt = wr_last ? ~wb_q : wb_q;
      rb_nxt = rd_rel  ? ~rb_q : rb_q;
   end

   // -------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q      <= 2'b00;
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         wcnt_q      <= '0;
         in_rdy_q    <= 1'b1;
         wait_q      <= '0;
         ridx_q      <= '0;
         q_vld_q     <= 1'b0;
         q_cnt_q     <= '0;
         symb_cnt_q  <= '0;
         symb_err_q  <= '0;
         rd_err_q    <= 1'b0;
         blk_avail_q <= 1'b0;
      end else begin
         full_q   <= full_nxt;
         wb_q     <= wb_nxt;
         rb_q     <= rb_nxt;
         wait_q   <= wait_nxt;
         ridx_q   <= ridx_nxt;
         if (wr_last) begin
            wcnt_q <= '0;
         end else if (wr_fire) begin
            wcnt_q <= wcnt_q + 1'b1;
         end
         // Registered flags are computed from the post-edge bank state so
         // a freed bank is reported ready in the very next cycle.
         in_rdy_q    <= ~full_nxt[wb_nxt];
         blk_avail_q <= (state_nxt == RD_IDLE) ? full_nxt[rb_nxt]
                                               : full_nxt[~rb_nxt];
         // Read pipeline: the index travels alongside the RAM read.
         q_vld_q    <= ram_rd_en;
         q_cnt_q    <= ram_rd_idx + 1'b1;
         symb_cnt_q <= q_vld_q ? q_cnt_q     : '0;
         symb_err_q <= q_vld_q ? ram_rd_data : '0;
         rd_err_q   <= rd_reject;
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.in_rdy        = in_rdy_q;
   assign bus.symb_cnt      = symb_cnt_q;
   assign bus.symb_with_err = symb_err_q;
   assign bus.blk_avail     = blk_avail_q;
   assign bus.rd_err        = rd_err_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_rx_symb_buf.sv
// -----------------------------------------------------------------------------
// tb_rx_symb_buf
// Directed bench for rx_symb_buf with a scoreboard: every accepted input
// symbol is pushed to exp_q, every replayed symbol is popped and compared.
// -----------------------------------------------------------------------------
module tb_rx_symb_buf;
   import rx_symb_buf_pkg::*;

   localparam int SYM_BW    = 8;
   localparam int N_NUM     = 255;
   localparam int START_LAT = 3;

   // ------------------------------------------------------ clock and reset
   logic      clk = 1'b0;
   logic      rst_n;
   rd_state_t dbg_state;

   always #5 clk = ~clk;

   rx_symb_buf_if #(.SYM_BW(SYM_BW)) bus ();

   rx_symb_buf #(
      .SYM_BW    (SYM_BW),
      .N_NUM     (N_NUM),
      .START_LAT (START_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   // ----------------------------------------------------------- scoreboard
   logic [SYM_BW-1:0] exp_q[$];
   int   n_vec    = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_cnt = 0;
   int   t0       = 0;
   logic exp_err  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   // Per-cycle output checks: rd_err against the bench's expectation, replay
   // index continuity, replayed data against the scoreboard.
   task automatic monitor();
      chk("rd_err", bus.rd_err, exp_err);
      if (bus.symb_cnt != '0) begin
         chk("symb_cnt_seq", bus.symb_cnt, last_cnt + 1);
         chk("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            chk("symb_with_err", bus.symb_with_err, exp_q.pop_front());
         end
         last_cnt = bus.symb_cnt;
      end else begin
         chk("idle_data_zero", bus.symb_with_err, 0);
         last_cnt = 0;
      end
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic tick();
      logic              acc;
      logic [SYM_BW-1:0] d;
      acc = bus.in_val && bus.in_rdy && rst_n;
      d   = bus.in_sym;
      @(posedge clk);
      cyc++;
      if (acc) exp_q.push_back(d);
      #1;
      monitor();
   endtask

   function automatic logic [SYM_BW-1:0] pat(input int sel, input int i);
      case (sel)
         0:       return SYM_BW'((i * 3) & 8'hFF);
         1:       return SYM_BW'($urandom_range(0, 255));
         2:       return (i == 0) ? 8'hAA : SYM_BW'((i * 7 + 1) & 8'hFF);
         default: return SYM_BW'(255 - i);
      endcase
   endfunction

   task automatic pulse_start(input logic rej);
      bus.rd_start = 1'b1;
      exp_err      = rej;
      tick();
      bus.rd_start = 1'b0;
      exp_err      = 1'b0;
   endtask

   // Writes n symbols at full rate (in_rdy must stay high throughout);
   // optionally pulses rd_start on write cycle start_off.
   task automatic write_block(input int n, input int sel, input int start_off, input logic rej);
      for (int i = 0; i < n; i++) begin
         bus.in_val = 1'b1;
         bus.in_sym = pat(sel, i);
         if (i == start_off) begin
            bus.rd_start = 1'b1;
            exp_err      = rej;
         end
         chk("in_rdy_wr", bus.in_rdy, 1);
         tick();
         bus.rd_start = 1'b0;
         exp_err      = 1'b0;
      end
      bus.in_val = 1'b0;
   endtask

   task automatic wait_cnt(input int target, input int max_cyc, input string tag);
      int n = 0;
      while (bus.symb_cnt != SYM_BW'(target) && n < max_cyc) begin
         tick();
         n++;
      end
      chk(tag, bus.symb_cnt, target);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_symb_cnt"}, bus.symb_cnt, 0);
      chk({tag, "_symb_with_err"}, bus.symb_with_err, 0);
      chk({tag, "_rd_err"}, bus.rd_err, 0);
      chk({tag, "_blk_avail"}, bus.blk_avail, 0);
      chk({tag, "_in_rdy"}, bus.in_rdy, 1);
      chk({tag, "_state"}, dbg_state, RD_IDLE);
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      rst_n        = 1'b0;
      bus.in_val   = 1'b0;
      bus.in_sym   = '0;
      bus.rd_start = 1'b0;
      tick();
      tick();
      chk_reset_vals("reset");
      rst_n = 1'b1;
      tick();

      // rd_start with nothing stored
      pulse_start(1'b1);
      chk("noblk_state", dbg_state, RD_IDLE);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("noblk_cnt", bus.symb_cnt, 0);
      end

      // One codeword i -> 3i, replay latency and length, reject at k=100
      write_block(N_NUM, 0, -1, 1'b0);
      chk("a_blk_avail", bus.blk_avail, 1);
      pulse_start(1'b0);
      t0 = cyc;
      chk("a_state_wait", dbg_state, RD_WAIT);
      tick();
      chk("a_state_wait2", dbg_state, RD_WAIT);
      tick();
      chk("a_cnt_t2", bus.symb_cnt, 0);
      tick();
      chk("a_cnt_t3", bus.symb_cnt, 1);
      while (cyc < t0 + 102) tick();
      chk("a_cnt_k100", bus.symb_cnt, 100);
      pulse_start(1'b1);
      chk("a_cnt_k101", bus.symb_cnt, 101);
      while (cyc < t0 + 257) tick();
      chk("a_cnt_t257", bus.symb_cnt, 255);
      tick();
      chk("a_cnt_t258", bus.symb_cnt, 0);
      chk("a_state_idle", dbg_state, RD_IDLE);
      chk("a_blk_avail_end", bus.blk_avail, 0);
      chk("a_sb_empty", exp_q.size(), 0);

      // Two codewords with no reads, then back-pressure with 0xAA held
      write_block(2 * N_NUM, 1, -1, 1'b0);
      chk("fill_rdy_low", bus.in_rdy, 0);
      chk("fill_blk_avail", bus.blk_avail, 1);
      bus.in_val = 1'b1;
      bus.in_sym = 8'hAA;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("fill_rdy_held", bus.in_rdy, 0);
      end
      pulse_start(1'b0);
      wait_cnt(N_NUM, 300, "fill_last");
      chk("fill_rdy_at_last", bus.in_rdy, 0);
      tick();
      chk("fill_end_cnt", bus.symb_cnt, 0);
      chk("fill_rdy_rise", bus.in_rdy, 1);
      chk("fill_blk_avail2", bus.blk_avail, 1);

      // Pending 0xAA lands first in the freed bank while the second codeword
      // is replayed concurrently
      write_block(N_NUM, 2, 0, 1'b0);
      chk("stream_blk_avail", bus.blk_avail, 1);
      chk("stream_state", dbg_state, RD_READ);
      wait_cnt(N_NUM, 300, "stream_b_last");
      tick();
      chk("stream_b_end", bus.symb_cnt, 0);
      chk("stream_blk_avail2", bus.blk_avail, 1);
      pulse_start(1'b0);
      wait_cnt(N_NUM, 300, "stream_c_last");
      tick();
      chk("stream_c_end", bus.symb_cnt, 0);
      chk("stream_sb_empty", exp_q.size(), 0);

      // rd_start on the same edge as the final write is rejected
      write_block(N_NUM, 3, N_NUM - 1, 1'b1);
      chk("same_edge_blk_avail", bus.blk_avail, 1);
      pulse_start(1'b0);
      t0 = cyc;
      while (cyc < t0 + 3) tick();
      chk("same_edge_cnt_t3", bus.symb_cnt, 1);
      wait_cnt(N_NUM, 300, "same_edge_last");
      tick();
      chk("same_edge_end", bus.symb_cnt, 0);

      // Reset in the middle of a replay, then a clean codeword
      write_block(N_NUM, 1, -1, 1'b0);
      pulse_start(1'b0);
      wait_cnt(50, 100, "mid_k50");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_vals("mid_reset");
      exp_q.delete();
      tick();
      chk("post_reset_cnt", bus.symb_cnt, 0);
      write_block(N_NUM, 0, -1, 1'b0);
      chk("post_reset_blk_avail", bus.blk_avail, 1);
      pulse_start(1'b0);
      wait_cnt(1, 10, "post_reset_first");
      wait_cnt(N_NUM, 300, "post_reset_last");
      tick();
      chk("post_reset_end", bus.symb_cnt, 0);
      chk("post_reset_sb_empty", exp_q.size(), 0);

      // --------------------------------------------------------- report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_symb_buf.md
RX_SYMB_BUF -- requirements
Module: rx_symb_buf

Interface
REQ-001 Parameter SYM_BW, default 8, symbol width in bits.
REQ-002 Parameter N_NUM, default 255, symbols per codeword (1..255).
REQ-003 Parameter START_LAT, default 3, cycles from accepted rd_start to first replayed symbol (>=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_val  input  1  received-symbol strobe; a symbol is written when in_val=1 and in_rdy=1.
REQ-007 in_sym  input  SYM_BW  received (possibly corrupted) symbol.
REQ-008 in_rdy  output  1  write bank free; registered.
REQ-009 rd_start  input  1  one-cycle pulse from the Forney stage, same pulse as the corrector's start.
REQ-010 symb_cnt  output  SYM_BW  replay index 1..N_NUM, 0 when idle; feeds the corrector's symb_cnt.
REQ-011 symb_with_err  output  SYM_BW  replayed stored symbol, aligned with symb_cnt; 0 when symb_cnt=0.
REQ-012 blk_avail  output  1  at least one complete codeword stored and not being replayed.
REQ-013 rd_err  output  1  one-cycle pulse: rd_start rejected.

Function
REQ-014 Two banks (ping-pong) of N_NUM symbols each, with registered flags full[1:0], write-bank pointer wb and read-bank pointer rb.
REQ-015 Write: accepted symbols are stored at address wcnt in bank wb; wcnt increments 0..N_NUM-1; on the N_NUM-th accept, set full[wb], toggle wb, and clear wcnt.
REQ-016 in_rdy = !full[wb], registered, evaluated on the post-edge state; with in_rdy=0, in_val is ignored and no data is written.
REQ-017 Read FSM states: IDLE, WAIT, READ.
REQ-018 IDLE: rd_start with full[rb]=1 -> WAIT; rd_start with full[rb]=0 -> rd_err=1 next cycle, stay IDLE.
REQ-019 WAIT: lasts START_LAT-1 cycles and issues RAM address 0 in its last cycle, so symb_cnt=1 appears exactly START_LAT cycles after the rd_start edge.
REQ-020 READ: outputs symb_cnt=k and symb_with_err=bank[rb][k-1] for k=1..N_NUM on consecutive cycles with no gaps; the cycle after k=N_NUM, symb_cnt=0, full[rb] clears, rb toggles, and the FSM returns to IDLE.
REQ-021 rd_start in WAIT or READ -> rd_err pulse; the replay in progress is unaffected.
REQ-022 blk_avail = full[rb] while IDLE, else full[!rb]; registered.
REQ-023 Simultaneous final write and rd_start on the same edge: the flag is sampled pre-edge, so the read is rejected with rd_err.
REQ-024 Simultaneous release of bank b by the read side and in_val waiting on bank b: in_rdy rises the cycle after release and no symbol is lost.
REQ-025 Simultaneous write and read on different banks: allowed every cycle at full rate.
REQ-026 Counters use SYM_BW-bit wrap-free arithmetic; N_NUM <= 2^SYM_BW-1 is a synthesis-time check.

Reset
REQ-027 With rst_n=0 at a clock edge: symb_cnt=0, symb_with_err=0, rd_err=0, blk_avail=0, in_rdy=1, full=0, wb=rb=0, wcnt=0, FSM=IDLE.
REQ-028 RAM contents are not reset; a partially written codeword or a replay in progress is discarded on reset.

Structure
REQ-029 SYM_BW and N_NUM defaults and the FSM state encoding live in the shared decoder package.
REQ-030 One sub-module, rs_sym_dpram: simple dual-port RAM of 2*N_NUM x SYM_BW, one write port, one read port with 1-cycle registered read; address = {bank, index}.

Verification
REQ-031 Write 255 symbols i->(i*3)&0xFF, rd_start at cycle t -> symb_cnt=1 at t+3, symb_cnt=255 at t+257, symb_with_err=(k-1)*3&0xFF, and symb_cnt=0 at t+258.
REQ-032 Fill two codewords with no reads -> in_rdy=0 after the 510th accept; in_val held high with data 0xAA is not written; after the first replay ends, in_rdy=1 on the next cycle.
REQ-033 rd_start with no stored block -> rd_err=1 one cycle later and symb_cnt stays 0; rd_start during READ at k=100 -> rd_err pulse and the replay continues to 255.
REQ-034 Continuous streaming: write block B while replaying block A -> both correct, no in_rdy drop, blk_avail=1 after B completes.
REQ-035 rst_n=0 mid-READ (k=50) -> all outputs equal reset values next cycle; a following 255-symbol write and replay is correct.
REQ-036 Final write and rd_start on the same edge -> rd_err pulse; rd_start one cycle later is accepted.
